alu_seq_ctrl: RTL
=================

Name: alu_seq_ctrl

Overview:
Parametrised successor to the board-level ALU top. It sequences operand/opcode entry from the switch bank through a debounced, edge-detected button FSM, drives the existing combinational ALU (NB_DATA/NB_OP generic), and presents a registered result with valid and status flags on the LEDs. It sits between the board I/O (switches, buttons, LEDs) and the ALU instance.

Parameters:
NB_DATA, 8, operand/result width in bits (>=4)
NB_OP, 6, opcode width; taken from i_sw_data[NB_OP-1:0] (NB_OP <= NB_DATA)
NB_SYNC, 2, synchroniser flops per button (>=2)

Ports:
clk  in  1  system clock
i_rst  in  1  synchronous active-high reset
i_btn  in  3  [0] load/advance, [1] clear, [2] edit opcode; asynchronous, level
i_sw_data  in  NB_DATA  signed switch data
o_led  out  NB_DATA  registered signed ALU result
o_valid  out  1  result register holds a result for the current A/B/OP
o_zero  out  1  registered: o_led == 0 (qualified by o_valid)
o_ovf  out  1  registered signed overflow for ADD/SUB, else 0
o_state  out  2  FSM state code for status LEDs

Behaviour:
- Reset (i_rst high at a clk edge): A=B=OP=0, o_led=0, o_valid=0, o_zero=0, o_ovf=0, state=S_A (o_state=00), synchronisers and edge registers cleared. Reset mid-sequence discards all partial entry.
- Button conditioning: each i_btn bit passes NB_SYNC flops, then a rising-edge detector (pulse = sync_out & ~prev). One pulse per press, regardless of hold length. With NB_SYNC=2: button sampled high at edge t -> pulse active during cycle after edge t+2 -> action committed at edge t+3.
- Pulse priority within one cycle: clear > edit > load; lower-priority pulses in the same cycle are dropped.
- States / o_state: S_A=00, S_B=01, S_OP=10, S_DONE=11.
  S_A: load -> A<=i_sw_data, go S_B.
  S_B: load -> B<=i_sw_data, go S_OP.
  S_OP: load -> OP<=i_sw_data[NB_OP-1:0], go S_DONE.
  S_DONE: load -> A<=i_sw_data, o_valid<=0, go S_B (new sequence). edit -> o_valid<=0, go S_OP (A, B kept).
  Any state: clear -> A=B=OP=0, o_valid=0, o_led=0, o_zero=o_ovf=0, go S_A.
  edit in S_A/S_B/S_OP: ignored.
- Result register: on the edge after entering S_DONE, o_led<=ALU(A,B,OP), o_zero, o_ovf updated, o_valid<=1. Latency: OP commit edge +1. o_led holds its value until the next result capture or clear; it is not updated in other states.
- ALU opcodes (NB_OP=6): ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111, SRA 000011, SRL 000010 (shift amount = B, shifts >= NB_DATA give 0 for SRL, sign fill for SRA). Any other code -> result 0, o_ovf 0.
- Arithmetic: two's complement, NB_DATA-bit wrap. ADD ovf = sign(A)==sign(B) && sign(R)!=sign(A); SUB ovf = sign(A)!=sign(B) && sign(R)!=sign(A).
- Switch changes outside a load pulse have no effect on any register.

Test Plan:
- Reset then no buttons 100 cycles -> o_led=0, o_valid=0, o_state=00.
- Load A=5, B=3, OP=100000 (one press each) -> o_state 00->01->10->11; one cycle after OP commit o_led=8, o_valid=1, o_zero=0, o_ovf=0.
- A=127 (0x7F), B=1, ADD -> o_led=0x80 (-128), o_ovf=1; then edit, OP=100010 SUB -> o_valid drops, then o_led=126, o_ovf=0.
- A=0xF0, B=2, SRA -> o_led=0xFC; SRL -> 0x3C; A=5,B=5,SUB -> o_led=0, o_zero=1.
- Hold i_btn[0] high 1000 cycles in S_A -> exactly one capture, state S_B only; i_btn[0] and i_btn[1] rising together in S_OP -> clear wins, state S_A, all zero.
- Assert i_rst for one cycle while in S_OP with A,B loaded -> next cycle all outputs at reset values; opcode 111111 after full entry -> o_led=0, o_valid=1.

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: button-sequenced operand/opcode entry for a combinational ALU.
// The buttons are synchronised and edge-detected. The operands and the opcode are
// latched from the switches, and the result is registered onto the LEDs together
// with the valid, zero and overflow flags.
// Ports:
//   clk        system clock
//   i_rst      synchronous active-high reset
//   i_btn      [0] load/advance, [1] clear, [2] edit opcode (asynchronous level inputs)
//   i_sw_data  signed switch data (operands; the opcode is taken from the low NB_OP bits)
//   o_led      registered signed ALU result
//   o_valid    result register matches the current A/B/OP
//   o_zero     registered (o_led == 0)
//   o_ovf      registered signed overflow for ADD/SUB
//   o_state    FSM state code
module alu_seq_ctrl #(
  parameter int unsigned NB_DATA = 8,
  parameter int unsigned NB_OP   = 6,
  parameter int unsigned NB_SYNC = 2
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic [2:0]         i_btn,
  input  logic [NB_DATA-1:0] i_sw_data,
  output logic [NB_DATA-1:0] o_led,
  output logic               o_valid,
  output logic               o_zero,
  output logic               o_ovf,
  output logic [1:0]         o_state
);

  localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(6'b100000);
  localparam logic [NB_OP-1:0] OP_SUB = NB_OP'(6'b100010);
  localparam logic [NB_OP-1:0] OP_AND = NB_OP'(6'b100100);
  localparam logic [NB_OP-1:0] OP_OR  = NB_OP'(6'b100101);
  localparam logic [NB_OP-1:0] OP_XOR = NB_OP'(6'b100110);
  localparam logic [NB_OP-1:0] OP_NOR = NB_OP'(6'b100111);
  localparam logic [NB_OP-1:0] OP_SRA = NB_OP'(6'b000011);
  localparam logic [NB_OP-1:0] OP_SRL = NB_OP'(6'b000010);

  typedef enum logic [1:0] {
    S_A    = 2'b00,
    S_B    = 2'b01,
    S_OP   = 2'b10,
    S_DONE = 2'b11
  } state_t;

  state_t state_q, state_d;

  logic [NB_DATA-1:0] a_q, a_d, b_q, b_d;
  logic [NB_OP-1:0]   op_q, op_d;
  logic               cap_q, cap_d;
  logic [NB_DATA-1:0] led_d;
  logic               valid_d, zero_d, ovf_d;

  // Button conditioning: synchroniser chain, then a registered rising-edge pulse
  logic [NB_SYNC-1:0] sync_q [3];
  logic [2:0]         sync_out, prev_q, pulse_q;

  always_comb begin
    sync_out = '0;
    for (int i = 0; i < 3; i++) sync_out[i] = sync_q[i][NB_SYNC-1];
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      for (int i = 0; i < 3; i++) sync_q[i] <= '0;
      prev_q  <= '0;
      pulse_q <= '0;
    end else begin
      for (int i = 0; i < 3; i++) sync_q[i] <= {sync_q[i][NB_SYNC-2:0], i_btn[i]};
      prev_q  <= sync_out;
      pulse_q <= sync_out & ~prev_q;
    end
  end

  // Pulse priority: clear > edit > load; losing pulses are dropped
  logic clr_p, edt_p, ld_p;
  assign clr_p = pulse_q[1];
  assign edt_p = pulse_q[2] & ~pulse_q[1];
  assign ld_p  = pulse_q[0] & ~pulse_q[1] & ~pulse_q[2];

  // Combinational ALU on the latched operands
  logic [NB_DATA-1:0] alu_r, add_r, sub_r;
  logic               alu_ovf;

  assign add_r = a_q + b_q;
  assign sub_r = a_q - b_q;

  always_comb begin
    alu_r   = '0;
    alu_ovf = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu_r   = add_r;
        alu_ovf = (a_q[NB_DATA-1] == b_q[NB_DATA-1]) && (add_r[NB_DATA-1] != a_q[NB_DATA-1]);
      end
      OP_SUB: begin
        alu_r   = sub_r;
        alu_ovf = (a_q[NB_DATA-1] != b_q[NB_DATA-1]) && (sub_r[NB_DATA-1] != a_q[NB_DATA-1]);
      end
      OP_AND:  alu_r = a_q & b_q;
      OP_OR:   alu_r = a_q | b_q;
      OP_XOR:  alu_r = a_q ^ b_q;
      OP_NOR:  alu_r = ~(a_q | b_q);
      // Oversized shift amounts yield sign fill / zero through the shift operators
      OP_SRA:  alu_r = NB_DATA'($signed(a_q) >>> b_q);
      OP_SRL:  alu_r = a_q >> b_q;
      default: alu_r = '0;
    endcase
  end

  // Next-state and register-update logic
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    cap_d   = 1'b0;
    led_d   = o_led;
    valid_d = o_valid;
    zero_d  = o_zero;
    ovf_d   = o_ovf;

    // Result capture one edge after entering S_DONE
    if (cap_q) begin
      led_d   = alu_r;
      zero_d  = (alu_r == '0);
      ovf_d   = alu_ovf;
      valid_d = 1'b1;
    end

    if (clr_p) begin
      state_d = S_A;
      a_d     = '0;
      b_d     = '0;
      op_d    = '0;
      led_d   = '0;
      valid_d = 1'b0;
      zero_d  = 1'b0;
      ovf_d   = 1'b0;
    end else if (edt_p) begin
      if (state_q == S_DONE) begin
        valid_d = 1'b0;
        state_d = S_OP;
      end
    end else if (ld_p) begin
      case (state_q)
        S_A: begin
          a_d     = i_sw_data;
          state_d = S_B;
        end
        S_B: begin
          b_d     = i_sw_data;
          state_d = S_OP;
        end
        S_OP: begin
          op_d    = i_sw_data[NB_OP-1:0];
          cap_d   = 1'b1;
          state_d = S_DONE;
        end
        default: begin
          a_d     = i_sw_data;
          valid_d = 1'b0;
          state_d = S_B;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q <= S_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      cap_q   <= 1'b0;
      o_led   <= '0;
      o_valid <= 1'b0;
      o_zero  <= 1'b0;
      o_ovf   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      cap_q   <= cap_d;
      o_led   <= led_d;
      o_valid <= valid_d;
      o_zero  <= zero_d;
      o_ovf   <= ovf_d;
    end
  end

  assign o_state = 2'(state_q);

endmodule
